// File: rtl/muller_c_formal_top.sv
// Bank of two-input Muller C-elements fed from the pad bus. Each element has
// a previous-output shadow for edge detection, sticky rise/fall flags, a
// saturating 4-phase completion counter and a sticky self-check flag. These
// are plain registers so formal properties can bind to them directly.

module muller_c_lane #(
  parameter logic RESET_VAL = 1'b0,
  parameter int   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             c,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  logic shadow;
  logic a_q;
  logic b_q;

  // C-element: follow agreeing inputs, hold on disagreement
  always_ff @(posedge clk) begin
    if (rst) c <= RESET_VAL;
    else if (a == b) c <= a;
  end

  // Previous output and previous sampled inputs, used by flags and self-check.
  // Inputs reset to an agreeing pair equal to RESET_VAL so the first edge
  // after reset checks cleanly against the reset output.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= RESET_VAL;
      a_q    <= RESET_VAL;
      b_q    <= RESET_VAL;
    end else begin
      shadow <= c;
      a_q    <= a;
      b_q    <= b;
    end
  end

  // Sticky edge flags and saturating count of falls (one per 4-phase cycle)
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
      cnt  <= '0;
    end else begin
      if (!shadow && c) rise <= 1'b1;
      if (shadow && !c) begin
        fall <= 1'b1;
        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Self-check: output may only move on agreeing inputs, and must match them
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (((a_q != b_q) && (c != shadow)) || ((a_q == b_q) && (c != a_q)))
      err <= 1'b1;
  end
endmodule

module muller_c_formal_top #(
  parameter int   N_ELEM    = 3,
  parameter logic RESET_VAL = 1'b0,
  parameter int   CNT_W     = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [2*N_ELEM-1:0]     io_in,
  output logic [N_ELEM-1:0]       c_out,
  output logic [N_ELEM-1:0]       rise_seen,
  output logic [N_ELEM-1:0]       fall_seen,
  output logic [N_ELEM*CNT_W-1:0] cycles_k,
  output logic                    cover_all,
  output logic                    err
);
  logic [N_ELEM-1:0] lane_err;

  for (genvar k = 0; k < N_ELEM; k++) begin : g_lane
    muller_c_lane #(.RESET_VAL(RESET_VAL), .CNT_W(CNT_W)) u_lane (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .a    (io_in[2*k]),
      .b    (io_in[2*k+1]),
      .c    (c_out[k]),
      .rise (rise_seen[k]),
      .fall (fall_seen[k]),
      .cnt  (cycles_k[k*CNT_W +: CNT_W]),
      .err  (lane_err[k])
    );
  end

  // Coverage goal: every element has toggled both ways; any lane error is global
  always_comb begin
    cover_all = &(rise_seen & fall_seen);
    err       = |lane_err;
  end
endmodule

// File: tb/tb_muller_c_formal_top.sv
// Directed bench for muller_c_formal_top. A history-based model tracks each
// element's output and counts observed transitions; a negedge process compares
// every DUT output to it, and literal checks pin the test-plan milestones.

module tb_muller_c_formal_top;
  localparam int N = 3;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*N-1:0] io;
  logic [N-1:0]   c_out, rise_seen, fall_seen;
  logic [N*W-1:0] cycles_k;
  logic           cover_all, err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: current output, output one edge ago, counts of observed rises/falls
  int m_c [N];
  int m_old [N];
  int n_rise [N];
  int n_fall [N];

  muller_c_formal_top #(.N_ELEM(N), .RESET_VAL(1'b0), .CNT_W(W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .io_in    (io),
    .c_out    (c_out),
    .rise_seen(rise_seen),
    .fall_seen(fall_seen),
    .cycles_k (cycles_k),
    .cover_all(cover_all),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Model advance: a transition of the output becomes visible in the flags and
  // counter one edge after it happens.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        m_c[k] = 0; m_old[k] = 0; n_rise[k] = 0; n_fall[k] = 0;
      end else begin
        if (m_old[k] == 0 && m_c[k] == 1) n_rise[k]++;
        if (m_old[k] == 1 && m_c[k] == 0) n_fall[k]++;
        m_old[k] = m_c[k];
        if (io[2*k] == io[2*k+1]) m_c[k] = io[2*k];
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0]   e_c, e_r, e_f;
      logic [N*W-1:0] e_cnt;
      logic           e_cov;
      e_cov = 1'b1;
      for (int k = 0; k < N; k++) begin
        e_c[k] = (m_c[k] != 0);
        e_r[k] = (n_rise[k] > 0);
        e_f[k] = (n_fall[k] > 0);
        e_cnt[k*W +: W] = W'((n_fall[k] > 255) ? 255 : n_fall[k]);
        e_cov = e_cov & e_r[k] & e_f[k];
      end
      checks++;
      if (c_out !== e_c || rise_seen !== e_r || fall_seen !== e_f ||
          cycles_k !== e_cnt || cover_all !== e_cov || err !== 1'b0) begin
        errors++;
        $display("FAIL model t=%0t got c=%b r=%b f=%b cnt=%h cov=%b err=%b exp c=%b r=%b f=%b cnt=%h cov=%b err=0",
                 $time, c_out, rise_seen, fall_seen, cycles_k, cover_all, err,
                 e_c, e_r, e_f, e_cnt, e_cov);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(input logic [2*N-1:0] v, input int n);
    io = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    io  = 6'b111111;
    repeat (2) @(negedge clk);
    chk("rst_c",    32'(c_out), 32'h0);
    chk("rst_rise", 32'(rise_seen), 32'h0);
    chk("rst_fall", 32'(fall_seen), 32'h0);
    chk("rst_cnt",  32'(cycles_k), 32'h0);
    chk("rst_err",  32'(err), 32'h0);
    rst = 1'b0;
    chk_en = 1;

    // Hold on disagreement, then follow once the pair agrees
    io = 6'b000010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_c0", 32'(c_out[0]), 32'h0);
    end
    step(6'b000011, 1);
    chk("agree_c0", 32'(c_out[0]), 32'h1);
    @(negedge clk);
    chk("rise0", 32'(rise_seen[0]), 32'h1);

    // Full handshake on element 1, element 0 held at 11
    step(6'b000011, 1); chk("hs_c1_a", 32'(c_out[1]), 32'h0);
    step(6'b000111, 1); chk("hs_c1_b", 32'(c_out[1]), 32'h0);
    step(6'b001111, 1); chk("hs_c1_c", 32'(c_out[1]), 32'h1);
    step(6'b001011, 1); chk("hs_c1_d", 32'(c_out[1]), 32'h1);
    step(6'b000011, 1); chk("hs_c1_e", 32'(c_out[1]), 32'h0);
    @(negedge clk);
    chk("hs_cnt1", 32'(cycles_k[W +: W]), 32'd1);
    chk("hs_fall1", 32'(fall_seen[1]), 32'h1);

    // All pairs high then low: every element has both edges
    step(6'b111111, 2);
    step(6'b000000, 2);
    chk("cover_all", 32'(cover_all), 32'h1);
    chk("err_after_cover", 32'(err), 32'h0);
    chk("cnt2_one", 32'(cycles_k[2*W +: W]), 32'd1);

    // Saturation on element 2
    for (int i = 0; i < 260; i++) begin
      step(6'b110000, 1);
      step(6'b000000, 1);
    end
    @(negedge clk);
    chk("sat_cnt2", 32'(cycles_k[2*W +: W]), 32'd255);
    step(6'b110000, 1);
    step(6'b000000, 2);
    chk("sat_hold", 32'(cycles_k[2*W +: W]), 32'd255);
    chk("cnt0_unchanged", 32'(cycles_k[0 +: W]), 32'd1);

    // Reset mid-operation with all outputs high
    step(6'b111111, 2);
    chk("pre_rst_c", 32'(c_out), 32'h7);
    rst = 1'b1;
    io  = 6'b101010;
    @(negedge clk);
    chk("mid_rst_c",   32'(c_out), 32'h0);
    chk("mid_rst_flg", 32'({rise_seen, fall_seen}), 32'h0);
    chk("mid_rst_cnt", 32'(cycles_k), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_c", 32'(c_out), 32'h0);
    chk("post_rst_cov", 32'(cover_all), 32'h0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
